// File: rtl/cordic_pkg.sv
// Shared constants and types for the CORDIC sharing controller.
// Holds default sizing, a constant clog2 helper and the {vld, id} tag layout.
package cordic_pkg;

  localparam int N_DEF    = 16;
  localparam int NREQ_DEF = 4;
  localparam int LAT_DEF  = 13;

  // Number of bits needed to encode 'value' distinct codes (minimum 1).
  function automatic int clog2_f(input int value);
    int result;
    result = 1;
    for (int i = 1; i < 31; i++) begin
      if ((32'd1 << i) < value) begin
        result = i + 1;
      end else begin
        result = result;
      end
    end
    return result;
  endfunction

  localparam int IDW_DEF = clog2_f(NREQ_DEF);

  // One tag pipe entry: valid bit plus the requester that issued the sample.
  typedef struct packed {
    logic               vld;
    logic [IDW_DEF-1:0] id;
  } tag_t;

endpackage

// File: rtl/cordic_share_ctrl_arbiter.sv
// Combinational round-robin arbiter. The search starts at ptr and wraps;
// the first asserted request wins. gnt is one-hot and only driven when en=1,
// while win always reports the search result so the caller can steer data.
module rr_arbiter
  import cordic_pkg::*;
#(
  parameter int NREQ = NREQ_DEF,
  parameter int IDW  = clog2_f(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  ptr,
  input  logic            en,
  output logic [NREQ-1:0] gnt,
  output logic [IDW-1:0]  win
);

  logic           found_s;
  logic [IDW-1:0] idx_s;

  // Rotating priority search beginning at the round-robin pointer.
  always_comb begin
    found_s = 1'b0;
    idx_s   = {IDW{1'b0}};
    win     = {IDW{1'b0}};
    for (int k = 0; k < NREQ; k++) begin
      idx_s = IDW'((int'(ptr) + k) % NREQ);
      if (!found_s && req[idx_s]) begin
        found_s = 1'b1;
        win     = idx_s;
      end else begin
        found_s = found_s;
      end
    end
  end

  // One-hot grant, suppressed while the pipeline is frozen.
  always_comb begin
    gnt = {NREQ{1'b0}};
    if (en && found_s) begin
      gnt[win] = 1'b1;
    end else begin
      gnt = {NREQ{1'b0}};
    end
  end

endmodule

// File: rtl/cordic_share_ctrl.sv
// Front-end that shares one pipelined CORDIC engine among several requesters.
// A round-robin arbiter issues at most one sample per cycle, a tag pipe the
// depth of the engine carries the requester ID alongside each sample, and a
// stalled result freezes both the engine (via enable) and the tag pipe.
module cordic_share_ctrl
  import cordic_pkg::*;
#(
  parameter int N    = N_DEF,
  parameter int NREQ = NREQ_DEF,
  parameter int LAT  = LAT_DEF,
  parameter int IDW  = clog2_f(NREQ)
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [NREQ*N-1:0] req_data,
  output logic [NREQ-1:0]   req_ready,
  output logic              rsp_valid,
  output logic [N-1:0]      rsp_data,
  output logic [IDW-1:0]    rsp_id,
  input  logic              rsp_ready,
  output logic              cordic_input_valid,
  output logic [N-1:0]      cordic_input_num,
  output logic              cordic_enable,
  input  logic [N-1:0]      cordic_output_num,
  input  logic              cordic_output_valid,
  output logic              tag_err
);

  localparam int             WW        = clog2_f(LAT + 1);
  localparam logic [WW-1:0]  WARM_FULL = WW'(LAT);
  localparam logic [IDW-1:0] LAST_ID   = IDW'(NREQ - 1);

  // Local tag layout sized by this instance's IDW.
  typedef struct packed {
    logic           vld;
    logic [IDW-1:0] id;
  } tag_s_t;

  logic            enable_s;
  logic            any_req_s;
  logic            issue_s;
  logic            armed_s;
  logic [IDW-1:0]  win_s;
  logic [NREQ-1:0] gnt_s;

  logic [IDW-1:0]  rr_ptr_q;
  logic [IDW-1:0]  rr_ptr_d;
  tag_s_t          tag_q [1:LAT];
  tag_s_t          tag_d [1:LAT];
  logic [WW-1:0]   warm_q;
  logic [WW-1:0]   warm_d;
  logic            tag_err_q;
  logic            tag_err_d;

  // A result waiting on a busy consumer freezes the whole pipeline.
  assign enable_s  = ~(tag_q[LAT].vld & ~rsp_ready);
  assign any_req_s = |req_valid;
  assign issue_s   = any_req_s & enable_s;

  rr_arbiter #(
    .NREQ (NREQ),
    .IDW  (IDW)
  ) u_arb (
    .req (req_valid),
    .ptr (rr_ptr_q),
    .en  (enable_s),
    .gnt (gnt_s),
    .win (win_s)
  );

  assign req_ready          = gnt_s;
  assign cordic_enable      = enable_s;
  assign cordic_input_valid = issue_s;

  // The tail of the tag pipe lines up with the engine output stage.
  assign rsp_valid = tag_q[LAT].vld;
  assign rsp_id    = tag_q[LAT].id;
  assign rsp_data  = cordic_output_num;
  assign tag_err   = tag_err_q;

  // The error check is meaningful only once the unreset engine has flushed.
  assign armed_s = (warm_q == WARM_FULL);

  // Steer the winning requester's sample to the engine; zero when idle.
  always_comb begin
    cordic_input_num = {N{1'b0}};
    if (issue_s) begin
      cordic_input_num = req_data[int'(win_s)*N +: N];
    end else begin
      cordic_input_num = {N{1'b0}};
    end
  end

  // Move the round-robin pointer just past the requester that was served.
  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (issue_s) begin
      if (win_s == LAST_ID) begin
        rr_ptr_d = {IDW{1'b0}};
      end else begin
        rr_ptr_d = win_s + IDW'(1'b1);
      end
    end else begin
      rr_ptr_d = rr_ptr_q;
    end
  end

  // Shift the tag pipe in lockstep with the engine pipeline.
  always_comb begin
    for (int i = 1; i <= LAT; i++) begin
      tag_d[i] = tag_q[i];
    end
    if (enable_s) begin
      tag_d[1].vld = issue_s;
      tag_d[1].id  = win_s;
      for (int i = 2; i <= LAT; i++) begin
        tag_d[i] = tag_q[i-1];
      end
    end else begin
      tag_d[1] = tag_q[1];
    end
  end

  // Count enabled edges since reset, saturating at the engine depth.
  always_comb begin
    warm_d = warm_q;
    if (enable_s && (warm_q != WARM_FULL)) begin
      warm_d = warm_q + WW'(1'b1);
    end else begin
      warm_d = warm_q;
    end
  end

  // Sticky flag when the engine valid and the tag pipe disagree.
  always_comb begin
    tag_err_d = tag_err_q;
    if (armed_s && (cordic_output_valid != tag_q[LAT].vld)) begin
      tag_err_d = 1'b1;
    end else begin
      tag_err_d = tag_err_q;
    end
  end

  // Round-robin pointer register.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rr_ptr_q <= {IDW{1'b0}};
    end else begin
      rr_ptr_q <= rr_ptr_d;
    end
  end

  // Tag pipe registers; reset drops every in-flight tag.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 1; i <= LAT; i++) begin
        tag_q[i] <= '0;
      end
    end else begin
      for (int i = 1; i <= LAT; i++) begin
        tag_q[i] <= tag_d[i];
      end
    end
  end

  // Warm-up counter register.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      warm_q <= {WW{1'b0}};
    end else begin
      warm_q <= warm_d;
    end
  end

  // Sticky tag error register.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      tag_err_q <= 1'b0;
    end else begin
      tag_err_q <= tag_err_d;
    end
  end

endmodule

// File: tb/tb_cordic_share_ctrl.sv
// Directed bench for cordic_share_ctrl with a behavioural 13-stage engine
// whose result is input ^ 16'hA5A5 and whose valid stages have no reset.
module tb_cordic_share_ctrl;

  localparam int N    = 16;
  localparam int NREQ = 4;
  localparam int LAT  = 13;
  localparam int IDW  = 2;

  logic              clk = 1'b0;
  logic              resetn;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ*N-1:0] req_data;
  logic [NREQ-1:0]   req_ready;
  logic              rsp_valid;
  logic [N-1:0]      rsp_data;
  logic [IDW-1:0]    rsp_id;
  logic              rsp_ready;
  logic              cordic_input_valid;
  logic [N-1:0]      cordic_input_num;
  logic              cordic_enable;
  logic [N-1:0]      cordic_output_num;
  logic              cordic_output_valid;
  logic              tag_err;
  logic              force_ov;

  int n_checks = 0;
  int n_fail   = 0;

  logic [N-1:0] src_d [4] = '{16'h1111, 16'h2222, 16'h3333, 16'h4444};
  logic [N-1:0] exp_d [4] = '{16'hB4B4, 16'h8787, 16'h9696, 16'hE1E1};

  logic         eng_v [1:LAT];
  logic [N-1:0] eng_d [1:LAT];

  always #5 clk = ~clk;

  // Engine model: advances only when enabled.
  always @(posedge clk) begin
    if (cordic_enable) begin
      eng_v[1] <= cordic_input_valid;
      eng_d[1] <= cordic_input_num ^ 16'hA5A5;
      for (int s = 2; s <= LAT; s++) begin
        eng_v[s] <= eng_v[s-1];
        eng_d[s] <= eng_d[s-1];
      end
    end
  end

  assign cordic_output_num   = eng_d[LAT];
  assign cordic_output_valid = eng_v[LAT] | force_ov;

  cordic_share_ctrl #(.N(N), .NREQ(NREQ), .LAT(LAT), .IDW(IDW)) dut (
    .clk                 (clk),
    .resetn              (resetn),
    .req_valid           (req_valid),
    .req_data            (req_data),
    .req_ready           (req_ready),
    .rsp_valid           (rsp_valid),
    .rsp_data            (rsp_data),
    .rsp_id              (rsp_id),
    .rsp_ready           (rsp_ready),
    .cordic_input_valid  (cordic_input_valid),
    .cordic_input_num    (cordic_input_num),
    .cordic_enable       (cordic_enable),
    .cordic_output_num   (cordic_output_num),
    .cordic_output_valid (cordic_output_valid),
    .tag_err             (tag_err)
  );

  task automatic do_reset();
    @(negedge clk);
    resetn = 1'b0; req_valid = '0; rsp_ready = 1'b1; force_ov = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    resetn = 1'b1;
    #1;
  endtask

  task automatic load_all();
    for (int i = 0; i < NREQ; i++) req_data[i*N +: N] = src_d[i];
  endtask

  task automatic test_reset();
    resetn = 1'b0; req_valid = '0; req_data = '0; rsp_ready = 1'b1; force_ov = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_checks++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rsp_valid: got %b want 0", rsp_valid); end
    n_checks++; if (cordic_input_valid !== 1'b0) begin n_fail++; $display("FAIL reset_in_valid: got %b want 0", cordic_input_valid); end
    n_checks++; if (req_ready !== 4'b0000) begin n_fail++; $display("FAIL reset_req_ready: got %b want 0000", req_ready); end
    n_checks++; if (tag_err !== 1'b0) begin n_fail++; $display("FAIL reset_tag_err: got %b want 0", tag_err); end
    n_checks++; if (cordic_enable !== 1'b1) begin n_fail++; $display("FAIL reset_enable: got %b want 1", cordic_enable); end
    @(negedge clk);
    resetn = 1'b1;
    req_valid = 4'b1111;
    #1;
    n_checks++; if (req_ready !== 4'b0001) begin n_fail++; $display("FAIL reset_rr_ptr: got %b want 0001", req_ready); end
    req_valid = '0;
  endtask

  task automatic test_single();
    int early;
    do_reset();
    req_data = '0;
    req_data[2*N +: N] = 16'h0100;
    req_valid = 4'b0100;
    #1;
    n_checks++; if (req_ready !== 4'b0100) begin n_fail++; $display("FAIL single_grant: got %b want 0100", req_ready); end
    n_checks++; if (cordic_input_num !== 16'h0100) begin n_fail++; $display("FAIL single_in_num: got %h want 0100", cordic_input_num); end
    @(posedge clk);
    #1 req_valid = '0;
    early = 0;
    for (int c = 1; c <= LAT; c++) begin
      @(negedge clk);
      #1;
      if (c == 1) begin
        n_checks++; if (req_ready !== 4'b0000) begin n_fail++; $display("FAIL single_ready_drop: got %b want 0000", req_ready); end
      end
      if (c < LAT && rsp_valid) early++;
    end
    n_checks++; if (early !== 0) begin n_fail++; $display("FAIL single_early: got %0d want 0", early); end
    n_checks++; if (rsp_valid !== 1'b1) begin n_fail++; $display("FAIL single_rsp_valid: got %b want 1", rsp_valid); end
    n_checks++; if (rsp_id !== 2'd2) begin n_fail++; $display("FAIL single_rsp_id: got %0d want 2", rsp_id); end
    n_checks++; if (rsp_data !== 16'hA4A5) begin n_fail++; $display("FAIL single_rsp_data: got %h want a4a5", rsp_data); end
    @(negedge clk);
    #1;
    n_checks++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL single_no_dup: got %b want 0", rsp_valid); end
  endtask

  task automatic test_back_to_back();
    logic [3:0] exp_g;
    do_reset();
    load_all();
    req_valid = 4'b1111;
    for (int i = 0; i < 6; i++) begin
      #1;
      exp_g = 4'b0001 << (i % 4);
      n_checks++; if (req_ready !== exp_g) begin n_fail++; $display("FAIL b2b_grant%0d: got %b want %b", i, req_ready, exp_g); end
      @(posedge clk);
      if (i == 5) begin
        #1 req_valid = '0;
      end
      @(negedge clk);
    end
    repeat (7) @(negedge clk);
    for (int j = 0; j < 6; j++) begin
      #1;
      n_checks++; if (rsp_valid !== 1'b1) begin n_fail++; $display("FAIL b2b_valid%0d: got %b want 1", j, rsp_valid); end
      n_checks++; if (rsp_id !== IDW'(j % 4)) begin n_fail++; $display("FAIL b2b_id%0d: got %0d want %0d", j, rsp_id, j % 4); end
      n_checks++; if (rsp_data !== exp_d[j % 4]) begin n_fail++; $display("FAIL b2b_data%0d: got %h want %h", j, rsp_data, exp_d[j % 4]); end
      @(negedge clk);
    end
    #1;
    n_checks++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_end: got %b want 0", rsp_valid); end
  endtask

  task automatic test_stall();
    int extra;
    do_reset();
    load_all();
    req_valid = 4'b1111;
    repeat (4) @(posedge clk);
    #1 req_valid = '0;
    repeat (10) @(negedge clk);
    #1;
    n_checks++; if (rsp_valid !== 1'b1 || rsp_id !== 2'd0) begin n_fail++; $display("FAIL stall_first: valid %b id %0d want 1/0", rsp_valid, rsp_id); end
    rsp_ready = 1'b0;
    req_data[0 +: N] = 16'h5555;
    req_valid = 4'b0001;
    for (int s = 0; s < 5; s++) begin
      #1;
      n_checks++; if (cordic_enable !== 1'b0) begin n_fail++; $display("FAIL stall_enable%0d: got %b want 0", s, cordic_enable); end
      n_checks++; if (req_ready !== 4'b0000) begin n_fail++; $display("FAIL stall_ready%0d: got %b want 0000", s, req_ready); end
      n_checks++; if (rsp_valid !== 1'b1 || rsp_id !== 2'd0 || rsp_data !== 16'hB4B4) begin
        n_fail++; $display("FAIL stall_hold%0d: valid %b id %0d data %h want 1/0/b4b4", s, rsp_valid, rsp_id, rsp_data);
      end
      @(negedge clk);
    end
    rsp_ready = 1'b1;
    #1;
    n_checks++; if (req_ready !== 4'b0001) begin n_fail++; $display("FAIL stall_resume_grant: got %b want 0001", req_ready); end
    @(posedge clk);
    #1 req_valid = '0;
    extra = 0;
    for (int c = 1; c <= LAT; c++) begin
      @(negedge clk);
      #1;
      if (c <= 3) begin
        n_checks++; if (rsp_valid !== 1'b1 || rsp_id !== IDW'(c) || rsp_data !== exp_d[c]) begin
          n_fail++; $display("FAIL stall_drain%0d: valid %b id %0d data %h want 1/%0d/%h", c, rsp_valid, rsp_id, rsp_data, c, exp_d[c]);
        end
      end else if (c < LAT && rsp_valid) begin
        extra++;
      end
    end
    n_checks++; if (extra !== 0) begin n_fail++; $display("FAIL stall_dup: got %0d want 0", extra); end
    n_checks++; if (rsp_valid !== 1'b1 || rsp_id !== 2'd0 || rsp_data !== 16'hF0F0) begin
      n_fail++; $display("FAIL stall_new: valid %b id %0d data %h want 1/0/f0f0", rsp_valid, rsp_id, rsp_data);
    end
  endtask

  task automatic test_sparse_rr();
    do_reset();
    req_data = '0;
    req_data[1*N +: N] = 16'h1001;
    req_valid = 4'b0010;
    #1;
    n_checks++; if (req_ready !== 4'b0010) begin n_fail++; $display("FAIL sparse_setup: got %b want 0010", req_ready); end
    @(posedge clk);
    #1 req_valid = '0;
    @(negedge clk);
    req_data[3*N +: N] = 16'h3003;
    req_valid = 4'b1010;
    #1;
    n_checks++; if (req_ready !== 4'b1000) begin n_fail++; $display("FAIL sparse_g0: got %b want 1000", req_ready); end
    @(posedge clk);
    @(negedge clk);
    #1;
    n_checks++; if (req_ready !== 4'b0010) begin n_fail++; $display("FAIL sparse_g1: got %b want 0010", req_ready); end
    @(posedge clk);
    @(negedge clk);
    #1;
    n_checks++; if (req_ready !== 4'b1000) begin n_fail++; $display("FAIL sparse_g2: got %b want 1000", req_ready); end
    @(posedge clk);
    #1 req_valid = '0;
    repeat (LAT + 2) @(negedge clk);
  endtask

  task automatic test_reset_midstream();
    int seen;
    do_reset();
    load_all();
    req_valid = 4'b1111;
    repeat (6) @(posedge clk);
    #1 req_valid = '0;
    @(negedge clk);
    resetn = 1'b0;
    #1;
    n_checks++; if (rsp_valid !== 1'b0 || req_ready !== 4'b0000 || cordic_input_valid !== 1'b0) begin
      n_fail++; $display("FAIL midrst_outputs: valid %b ready %b in_valid %b want 0/0000/0", rsp_valid, req_ready, cordic_input_valid);
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    resetn = 1'b1;
    seen = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      #1;
      if (rsp_valid) seen++;
    end
    n_checks++; if (seen !== 0) begin n_fail++; $display("FAIL midrst_ghost: got %0d want 0", seen); end
    n_checks++; if (tag_err !== 1'b0) begin n_fail++; $display("FAIL midrst_tag_err: got %b want 0", tag_err); end
    req_valid = 4'b1111;
    #1;
    n_checks++; if (req_ready !== 4'b0001) begin n_fail++; $display("FAIL midrst_rr_ptr: got %b want 0001", req_ready); end
    req_valid = '0;
  endtask

  task automatic test_tag_err();
    do_reset();
    repeat (12) begin
      @(posedge clk);
      @(negedge clk);
    end
    force_ov = 1'b1;
    @(posedge clk);
    @(negedge clk);
    force_ov = 1'b0;
    #1;
    n_checks++; if (tag_err !== 1'b0) begin n_fail++; $display("FAIL tagerr_unarmed: got %b want 0", tag_err); end
    force_ov = 1'b1;
    @(posedge clk);
    @(negedge clk);
    force_ov = 1'b0;
    #1;
    n_checks++; if (tag_err !== 1'b1) begin n_fail++; $display("FAIL tagerr_set: got %b want 1", tag_err); end
    repeat (3) @(negedge clk);
    #1;
    n_checks++; if (tag_err !== 1'b1) begin n_fail++; $display("FAIL tagerr_sticky: got %b want 1", tag_err); end
    do_reset();
    n_checks++; if (tag_err !== 1'b0) begin n_fail++; $display("FAIL tagerr_clear: got %b want 0", tag_err); end
  endtask

  initial begin
    resetn    = 1'b0;
    req_valid = '0;
    req_data  = '0;
    rsp_ready = 1'b1;
    force_ov  = 1'b0;
    test_reset();
    test_single();
    test_back_to_back();
    test_stall();
    test_sparse_rr();
    test_reset_midstream();
    test_tag_err();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
